// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the fetch/memory pipeline stages, the arbiter and a single-port memory.
// Both requesters hold a level req with stable addr/we/wdata until their one-cycle ack.
interface mips_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Pipeline/memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed DM priority.
module mips_mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mips_mem_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        gnt_dm_q, gnt_dm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        pick_dm;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_dm_q, last_dm_d;

  // On contention the side not granted last wins; otherwise whoever asks.
  assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm_q);

  always_ff @(posedge clk) begin
    if (!reset) last_dm_q <= 1'b0;
    else        last_dm_q <= last_dm_d;
  end
`else
  assign pick_dm = bus.dm_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= 2'd0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_dm_d  = last_dm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d  = ISSUE;
          gnt_dm_d = pick_dm;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_dm_d = pick_dm;
`endif
          if (pick_dm) begin
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.if_addr;
            wdata_d = 32'h0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ACK;
          // Writes leave the requester's read register untouched.
          if (!we_q) begin
            if (gnt_dm_q) dm_rdata_d = bus.mem_rdata;
            else          if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_ack    = (state_q == ACK) & ~gnt_dm_q;
  assign bus.dm_ack    = (state_q == ACK) &  gnt_dm_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_ack;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_ack;

  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 The block SHALL provide parameter MEM_LAT, default 1, legal 1..4: cycles from the mem_en cycle to the cycle mem_rdata is valid.
REQ-002 The block SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL provide port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL provide ports if_req input 1, if_addr input 32: instruction-fetch request, level, held until if_ack.
REQ-005 The block SHALL provide ports if_rdata output 32, if_ack output 1, if_stall output 1: fetch response, one-cycle ack, fetch-stage stall.
REQ-006 The block SHALL provide ports dm_req input 1, dm_we input 1, dm_addr input 32, dm_wdata input 32: data-memory request, level, held until dm_ack.
REQ-007 The block SHALL provide ports dm_rdata output 32, dm_ack output 1, dm_stall output 1: load response, one-cycle ack, memory-stage stall.
REQ-008 The block SHALL provide ports mem_en output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32, mem_rdata input 32: single-port memory.
REQ-009 The block SHALL provide port busy output 1, high whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-011 In IDLE with at least one req high, the block SHALL grant one requester, latch its addr/we/wdata (IF: we=0), and enter ISSUE at the next edge.
REQ-012 In ISSUE (exactly one cycle) mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values; next state WAIT.
REQ-013 mem_en SHALL be 0 in all states other than ISSUE; mem_we SHALL be 0 outside ISSUE.
REQ-014 In WAIT a counter loaded with MEM_LAT-1 SHALL decrement; when 0, mem_rdata SHALL be registered into the granted requester's rdata and state SHALL go to ACK.
REQ-015 In ACK (exactly one cycle) only the granted requester's ack SHALL be 1; next state IDLE; requests are not sampled in ACK.
REQ-016 Request-to-ack latency SHALL be MEM_LAT+2 cycles from the IDLE cycle with req high; throughput one access per MEM_LAT+3 cycles.
REQ-017 For a data write (dm_we=1) dm_rdata SHALL hold its previous value; dm_ack still pulses.
REQ-018 if_rdata/dm_rdata SHALL hold their value until the next completed read for that requester.
REQ-019 if_stall SHALL equal if_req AND NOT if_ack; dm_stall SHALL equal dm_req AND NOT dm_ack (combinational).
REQ-020 Input changes on addr/we/wdata after the grant SHALL be ignored until ACK.
REQ-021 A req deasserted after grant SHALL NOT abort the access; the access completes and ack pulses.
REQ-022 Simultaneous if_req and dm_req in IDLE SHALL be resolved by the policy of REQ-026/027; the loser keeps stall high and is served at the next IDLE.

Reset
REQ-023 With reset low at a rising edge, state SHALL become IDLE and mem_en, mem_we, if_ack, dm_ack, busy SHALL be 0; mem_addr, mem_wdata, if_rdata, dm_rdata SHALL be 0x00000000.
REQ-024 Reset asserted mid-access SHALL abort the access with no ack and no rdata update.
REQ-025 After reset the round-robin last-grant pointer SHALL indicate IF.

Configuration
REQ-026 With macro MEM_ARB_ROUND_ROBIN_EN defined, on contention the requester not granted last SHALL win; the pointer updates on every grant.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN, on contention DM SHALL always win (fixed priority); no pointer register exists.

Verification
REQ-028 MEM_LAT=1, reset low 2 cycles then high -> all outputs 0, busy 0, mem_en never 1 with no reqs.
REQ-029 MEM_LAT=1, if_req=1 if_addr=0x00000010, mem_rdata=0x8C220004 -> mem_en one cycle with mem_addr 0x10, if_ack 3 cycles after req, if_rdata=0x8C220004, if_stall 1 until ack.
REQ-030 dm_req=1 dm_we=1 dm_addr=0x100 dm_wdata=0xDEADBEEF -> one ISSUE cycle mem_we=1 mem_wdata=0xDEADBEEF, dm_ack pulses, dm_rdata unchanged.
REQ-031 Both reqs held high, 4 accesses, macro defined -> grant order DM, IF, DM, IF; macro undefined -> DM served until dm_req drops, IF stalled.
REQ-032 MEM_LAT=3, reset low during WAIT -> no ack, next cycle IDLE, rdata registers 0.
REQ-033 if_addr changed 0x10->0x20 during WAIT -> access uses 0x10, if_ack pulses once.
